// File: rtl/cva6_periph_bridge_if.sv
// AXI4 slave port plus register-bus master port of the peripheral bridge.
// "slave" is the bridge's view, "master" is the view of whoever drives it.
interface cva6_periph_bridge_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4
);
    localparam int StrbWidth = DataWidth / 8;

    // AW channel
    logic                 awvalid_i;
    logic                 awready_o;
    logic [IdWidth-1:0]   awid_i;
    logic [AddrWidth-1:0] awaddr_i;
    logic [7:0]           awlen_i;
    // W channel
    logic                 wvalid_i;
    logic                 wready_o;
    logic [DataWidth-1:0] wdata_i;
    logic [StrbWidth-1:0] wstrb_i;
    logic                 wlast_i;
    // B channel
    logic                 bvalid_o;
    logic                 bready_i;
    logic [IdWidth-1:0]   bid_o;
    logic [1:0]           bresp_o;
    // AR channel
    logic                 arvalid_i;
    logic                 arready_o;
    logic [IdWidth-1:0]   arid_i;
    logic [AddrWidth-1:0] araddr_i;
    logic [7:0]           arlen_i;
    // R channel
    logic                 rvalid_o;
    logic                 rready_i;
    logic [IdWidth-1:0]   rid_o;
    logic [DataWidth-1:0] rdata_o;
    logic [1:0]           rresp_o;
    logic                 rlast_o;
    // register bus
    logic                 reg_req_o;
    logic                 reg_we_o;
    logic [AddrWidth-1:0] reg_addr_o;
    logic [DataWidth-1:0] reg_wdata_o;
    logic [StrbWidth-1:0] reg_be_o;
    logic                 reg_ready_i;
    logic                 reg_error_i;
    logic [DataWidth-1:0] reg_rdata_i;

    modport slave (
        input  awvalid_i, awid_i, awaddr_i, awlen_i,
        output awready_o,
        input  wvalid_i, wdata_i, wstrb_i, wlast_i,
        output wready_o,
        output bvalid_o, bid_o, bresp_o,
        input  bready_i,
        input  arvalid_i, arid_i, araddr_i, arlen_i,
        output arready_o,
        output rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
        input  rready_i,
        output reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, reg_be_o,
        input  reg_ready_i, reg_error_i, reg_rdata_i
    );

    modport master (
        output awvalid_i, awid_i, awaddr_i, awlen_i,
        input  awready_o,
        output wvalid_i, wdata_i, wstrb_i, wlast_i,
        input  wready_o,
        input  bvalid_o, bid_o, bresp_o,
        output bready_i,
        output arvalid_i, arid_i, araddr_i, arlen_i,
        input  arready_o,
        input  rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
        output rready_i,
        input  reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, reg_be_o,
        output reg_ready_i, reg_error_i, reg_rdata_i
    );
endinterface

// File: rtl/cva6_periph_bridge.sv
// Uncached AXI4 -> single register bus bridge for non-idempotent peripherals.
// One transaction in flight; bursts are refused with SLVERR and never touch
// the register bus; stuck register accesses are cut off by a timeout.
module cva6_periph_bridge #(
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int IdWidth       = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cva6_periph_bridge_if.slave  bus
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int CntW      = $clog2(TimeoutCycles) + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_DATA  = 3'd1;
    localparam logic [2:0] WR_REQ   = 3'd2;
    localparam logic [2:0] WR_DRAIN = 3'd3;
    localparam logic [2:0] WR_RESP  = 3'd4;
    localparam logic [2:0] RD_REQ   = 3'd5;
    localparam logic [2:0] RD_RESP  = 3'd6;

    logic [2:0]           state_q, state_d;
    logic                 prio_q, prio_d;     // 0: read wins contention, 1: write wins
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic [7:0]           beat_q, beat_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           resp_q, resp_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic idle, contended, aw_gnt, ar_gnt, timeout;

    assign idle      = (state_q == IDLE);
    assign contended = bus.awvalid_i && bus.arvalid_i;
    assign aw_gnt    = bus.awvalid_i && (!bus.arvalid_i || prio_q);
    assign ar_gnt    = bus.arvalid_i && (!bus.awvalid_i || !prio_q);
    assign timeout   = (cnt_q == CntW'(TimeoutCycles - 1));

    // Readies drop the losing side of a contended pair so only one address
    // handshake can happen per cycle; reset forces them low immediately.
    assign bus.awready_o = !rst_i && idle && !(bus.arvalid_i && !prio_q);
    assign bus.arready_o = !rst_i && idle && !(bus.awvalid_i && prio_q);
    assign bus.wready_o  = (state_q == WR_DATA) || (state_q == WR_DRAIN);

    assign bus.bvalid_o  = (state_q == WR_RESP);
    assign bus.bid_o     = id_q;
    assign bus.bresp_o   = resp_q;

    assign bus.rvalid_o  = (state_q == RD_RESP);
    assign bus.rid_o     = id_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.rresp_o   = resp_q;
    assign bus.rlast_o   = (state_q == RD_RESP) && (beat_q == len_q);

    assign bus.reg_req_o   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign bus.reg_we_o    = (state_q == WR_REQ);
    assign bus.reg_addr_o  = addr_q & ~AddrWidth'(StrbWidth - 1);
    assign bus.reg_wdata_o = wdata_q;
    assign bus.reg_be_o    = (state_q == RD_REQ) ? {StrbWidth{1'b1}} : wstrb_q;

    // Next-state and datapath capture for the single in-flight transaction.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        beat_d  = beat_q;
        cnt_d   = '0;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (ar_gnt) begin
                    id_d   = bus.arid_i;
                    addr_d = bus.araddr_i;
                    len_d  = bus.arlen_i;
                    if (contended) prio_d = 1'b1;
                    if (bus.arlen_i == 8'd0) begin
                        state_d = RD_REQ;
                    end else begin
                        // bursts are not forwarded: answer every beat with an error
                        resp_d  = RESP_SLVERR;
                        rdata_d = '0;
                        state_d = RD_RESP;
                    end
                end else if (aw_gnt) begin
                    id_d    = bus.awid_i;
                    addr_d  = bus.awaddr_i;
                    len_d   = bus.awlen_i;
                    if (contended) prio_d = 1'b0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.wvalid_i) begin
                    if (len_q == 8'd0) begin
                        wdata_d = bus.wdata_i;
                        wstrb_d = bus.wstrb_i;
                        state_d = WR_REQ;
                    end else if (bus.wlast_i) begin
                        resp_d  = RESP_SLVERR;
                        state_d = WR_RESP;
                    end else begin
                        state_d = WR_DRAIN;
                    end
                end
            end
            WR_DRAIN: begin
                if (bus.wvalid_i && bus.wlast_i) begin
                    resp_d  = RESP_SLVERR;
                    state_d = WR_RESP;
                end
            end
            WR_REQ: begin
                if (bus.reg_ready_i) begin
                    resp_d  = bus.reg_error_i ? RESP_SLVERR : RESP_OKAY;
                    state_d = WR_RESP;
                end else if (timeout) begin
                    resp_d  = RESP_SLVERR;
                    state_d = WR_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_RESP: begin
                if (bus.bready_i) state_d = IDLE;
            end
            RD_REQ: begin
                if (bus.reg_ready_i) begin
                    rdata_d = bus.reg_rdata_i;
                    resp_d  = bus.reg_error_i ? RESP_SLVERR : RESP_OKAY;
                    state_d = RD_RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    resp_d  = RESP_SLVERR;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_RESP: begin
                if (bus.rready_i) begin
                    if (beat_q == len_q) state_d = IDLE;
                    else                 beat_d  = beat_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight transaction without a response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_cva6_periph_bridge.sv
// Scoreboard bench for cva6_periph_bridge: expectations are queued as stimulus
// is issued and retired by the register-side responder and the B/R monitors.
module tb_cva6_periph_bridge;
    localparam int AW = 64, DW = 64, IW = 4, SW = DW / 8, TO = 16;
    localparam logic [1:0] OKAY = 2'b00, SLV = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cva6_periph_bridge_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

    cva6_periph_bridge #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_t;
    typedef struct { logic we; logic [AW-1:0] addr; logic [SW-1:0] be; logic [DW-1:0] wdata; } g_t;

    b_t exp_b[$];
    r_t exp_r[$];
    g_t exp_g[$];

    int n_chk = 0, n_bad = 0, cyc = 0;
    int rdy_dly = 0;
    logic rsp_err = 1'b0;
    logic [DW-1:0] rsp_rdata = '0;
    int req_run = 0, req_last = 0, req_total = 0;
    int b_rise = 0, r_rise = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // register-side responder: answers after rdy_dly request cycles (-1 = never)
    initial begin : reg_side
        int wcnt;
        g_t g;
        wcnt = 0;
        bus.reg_ready_i = 1'b0;
        bus.reg_error_i = 1'b0;
        bus.reg_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (bus.reg_req_o === 1'b1) begin
                req_run++;
                req_total++;
                if (rdy_dly >= 0 && wcnt >= rdy_dly) begin
                    bus.reg_ready_i = 1'b1;
                    bus.reg_error_i = rsp_err;
                    bus.reg_rdata_i = rsp_rdata;
                    if (exp_g.size() == 0) chk("reg_unexp", 1, 0);
                    else begin
                        g = exp_g.pop_front();
                        chk("reg_we", bus.reg_we_o, g.we);
                        chk("reg_addr", bus.reg_addr_o, g.addr);
                        chk("reg_be", bus.reg_be_o, g.be);
                        if (g.we) chk("reg_wdata", bus.reg_wdata_o, g.wdata);
                    end
                end else begin
                    bus.reg_ready_i = 1'b0;
                end
                wcnt++;
            end else begin
                bus.reg_ready_i = 1'b0;
                wcnt = 0;
                if (req_run > 0) begin
                    req_last = req_run;
                    req_run  = 0;
                end
            end
        end
    end

    initial begin : b_mon
        logic prev;
        b_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.bvalid_o && !prev) b_rise = cyc;
            prev = bus.bvalid_o;
            if (bus.bvalid_o && bus.bready_i) begin
                if (exp_b.size() == 0) chk("b_unexp", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    chk("bid", bus.bid_o, e.id);
                    chk("bresp", bus.bresp_o, e.resp);
                end
            end
        end
    end

    initial begin : r_mon
        logic prev;
        r_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rvalid_o && !prev) r_rise = cyc;
            prev = bus.rvalid_o;
            if (bus.rvalid_o && bus.rready_i) begin
                if (exp_r.size() == 0) chk("r_unexp", 1, 0);
                else begin
                    e = exp_r.pop_front();
                    chk("rid", bus.rid_o, e.id);
                    chk("rdata", bus.rdata_o, e.data);
                    chk("rresp", bus.rresp_o, e.resp);
                    chk("rlast", bus.rlast_o, e.last);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic set_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len);
        bus.awid_i = id; bus.awaddr_i = a; bus.awlen_i = len;
    endtask
    task automatic set_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len);
        bus.arid_i = id; bus.araddr_i = a; bus.arlen_i = len;
    endtask
    task automatic set_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        bus.wdata_i = d; bus.wstrb_i = s; bus.wlast_i = last;
    endtask
    task automatic pb(input logic [IW-1:0] id, input logic [1:0] resp);
        b_t e; e.id = id; e.resp = resp; exp_b.push_back(e);
    endtask
    task automatic pr(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        r_t e; e.id = id; e.data = d; e.resp = resp; e.last = last; exp_r.push_back(e);
    endtask
    task automatic pg(input logic we, input logic [AW-1:0] a, input logic [SW-1:0] be, input logic [DW-1:0] d);
        g_t e; e.we = we; e.addr = a; e.be = be; e.wdata = d; exp_g.push_back(e);
    endtask

    // raise the selected valids together; each drops after its own handshake
    task automatic run_txn(input bit aw_en, input bit ar_en, input bit w_en,
                           output int aw_c, output int ar_c, output int w_c);
        bit awp, arp, wp;
        int n;
        awp = aw_en; arp = ar_en; wp = w_en; n = 0;
        aw_c = -1; ar_c = -1; w_c = -1;
        bus.awvalid_i = awp; bus.arvalid_i = arp; bus.wvalid_i = wp;
        while ((awp || arp || wp) && n < 300) begin
            @(negedge clk);
            if (awp && bus.awready_o) begin aw_c = cyc; awp = 1'b0; end
            if (arp && bus.arready_o) begin ar_c = cyc; arp = 1'b0; end
            if (wp && bus.wready_o)   begin w_c = cyc;  wp = 1'b0; end
            @(posedge clk);
            #1;
            bus.awvalid_i = awp; bus.arvalid_i = arp; bus.wvalid_i = wp;
            n++;
        end
        if (awp || arp || wp) chk("hs_timeout", 1, 0);
        bus.awvalid_i = 1'b0; bus.arvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_b.size() + exp_r.size() + exp_g.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("drain_timeout", exp_b.size() + exp_r.size() + exp_g.size(), 0);
            exp_b.delete(); exp_r.delete(); exp_g.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit is_b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_b ? bus.bvalid_o : bus.rvalid_o) && n < 50);
        if (n >= 50) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int ac, rc, wc, base;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [IW-1:0] id;
        bus.awvalid_i = 0; bus.arvalid_i = 0; bus.wvalid_i = 0;
        bus.bready_i = 1; bus.rready_i = 1;
        set_aw('0, '0, '0); set_ar('0, '0, '0); set_w('0, '0, 1'b0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", bus.awready_o, 0);
        chk("rst_arready", bus.arready_o, 0);
        chk("rst_req", bus.reg_req_o, 0);
        chk("rst_bvalid", bus.bvalid_o, 0);
        chk("rst_rvalid", bus.rvalid_o, 0);
        rst = 1'b0;
        #1;
        chk("idle_awready", bus.awready_o, 1);
        @(posedge clk);
        #1;

        // single write, ready after 2 cycles
        rdy_dly = 2; rsp_err = 0;
        set_aw(4'h6, 64'h2000_0008, 8'd0); set_w(64'hA5, 8'h01, 1'b1);
        pg(1, 64'h2000_0008, 8'h01, 64'hA5); pb(4'h6, OKAY);
        run_txn(1, 0, 1, ac, rc, wc); wait_idle();

        // single read returning error with data
        rdy_dly = 1; rsp_err = 1; rsp_rdata = 64'hDEAD_BEEF;
        set_ar(4'h9, 64'h1000_0004, 8'd0);
        pg(0, 64'h1000_0000, 8'hFF, '0); pr(4'h9, 64'hDEAD_BEEF, SLV, 1);
        run_txn(0, 1, 0, ac, rc, wc); wait_idle();

        // minimum latency, unaligned write address
        rdy_dly = 0; rsp_err = 0;
        set_aw(4'h2, 64'h3000_001F, 8'd0); set_w(64'h1122_3344_5566_7788, 8'hF0, 1'b1);
        pg(1, 64'h3000_0018, 8'hF0, 64'h1122_3344_5566_7788); pb(4'h2, OKAY);
        run_txn(1, 0, 1, ac, rc, wc); wait_idle();
        chk("lat_b", b_rise - ac, 3);
        rsp_rdata = 64'h0BAD_F00D;
        set_ar(4'h4, 64'h3000_0010, 8'd0);
        pg(0, 64'h3000_0010, 8'hFF, '0); pr(4'h4, 64'h0BAD_F00D, OKAY, 1);
        run_txn(0, 1, 0, ac, rc, wc); wait_idle();
        chk("lat_r", r_rise - rc, 2);

        // read burst: four error beats, no register access
        base = req_total;
        set_ar(4'h7, 64'h4000_0000, 8'd3);
        for (int i = 0; i < 4; i++) pr(4'h7, '0, SLV, i == 3);
        run_txn(0, 1, 0, ac, rc, wc); wait_idle();
        chk("burst_rd_noreq", req_total - base, 0);

        // write burst: two beats drained, one error response
        base = req_total;
        set_aw(4'h8, 64'h4000_0008, 8'd1); pb(4'h8, SLV);
        set_w(64'h1, 8'hFF, 1'b0); run_txn(1, 0, 1, ac, rc, wc);
        set_w(64'h2, 8'hFF, 1'b1); run_txn(0, 0, 1, ac, rc, wc);
        wait_idle();
        chk("burst_wr_noreq", req_total - base, 0);

        // timeouts
        rdy_dly = -1;
        set_aw(4'h3, 64'h5000_0000, 8'd0); set_w(64'h33, 8'h03, 1'b1); pb(4'h3, SLV);
        run_txn(1, 0, 1, ac, rc, wc); wait_idle();
        chk("to_wr_len", req_last, TO);
        set_ar(4'h5, 64'h5000_0008, 8'd0); pr(4'h5, '0, SLV, 1);
        run_txn(0, 1, 0, ac, rc, wc); wait_idle();
        chk("to_rd_len", req_last, TO);

        // stalled B and R keep payload stable
        rdy_dly = 0; rsp_err = 0;
        bus.bready_i = 0;
        set_aw(4'hA, 64'h6000_0000, 8'd0); set_w(64'h66, 8'hFF, 1'b1);
        pg(1, 64'h6000_0000, 8'hFF, 64'h66); pb(4'hA, OKAY);
        run_txn(1, 0, 1, ac, rc, wc); wait_valid(1);
        repeat (5) begin
            @(negedge clk);
            chk("bstall_v", bus.bvalid_o, 1);
            chk("bstall_id", bus.bid_o, 4'hA);
            chk("bstall_resp", bus.bresp_o, OKAY);
        end
        @(posedge clk); #1; bus.bready_i = 1; wait_idle();
        bus.rready_i = 0; rsp_rdata = 64'hCAFE;
        set_ar(4'hB, 64'h6000_0010, 8'd0);
        pg(0, 64'h6000_0010, 8'hFF, '0); pr(4'hB, 64'hCAFE, OKAY, 1);
        run_txn(0, 1, 0, ac, rc, wc); wait_valid(0);
        repeat (5) begin
            @(negedge clk);
            chk("rstall_v", bus.rvalid_o, 1);
            chk("rstall_id", bus.rid_o, 4'hB);
            chk("rstall_data", bus.rdata_o, 64'hCAFE);
            chk("rstall_last", bus.rlast_o, 1);
        end
        @(posedge clk); #1; bus.rready_i = 1; wait_idle();

        // reset during WR_REQ drops the write
        rdy_dly = -1;
        set_aw(4'hC, 64'h8000_0000, 8'd0); set_w(64'hCC, 8'hFF, 1'b1);
        run_txn(1, 0, 1, ac, rc, wc);
        chk("pre_rst_req", bus.reg_req_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", bus.reg_req_o, 0);
        chk("mid_rst_we", bus.reg_we_o, 0);
        chk("mid_rst_addr", bus.reg_addr_o, 0);
        chk("mid_rst_be", bus.reg_be_o, 0);
        chk("mid_rst_wdata", bus.reg_wdata_o, 0);
        chk("mid_rst_bvalid", bus.bvalid_o, 0);
        chk("mid_rst_awready", bus.awready_o, 0);
        chk("mid_rst_wready", bus.wready_o, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rdy_dly = 1;
        set_aw(4'hD, 64'h8000_0020, 8'd0); set_w(64'hDD, 8'h80, 1'b1);
        pg(1, 64'h8000_0020, 8'h80, 64'hDD); pb(4'hD, OKAY);
        run_txn(1, 0, 1, ac, rc, wc); wait_idle();

        // contention: read wins first, then write wins the next round
        rsp_rdata = 64'h77;
        set_ar(4'h1, 64'h7000_0008, 8'd0);
        set_aw(4'h2, 64'h7000_0010, 8'd0); set_w(64'h55, 8'h0F, 1'b1);
        pg(0, 64'h7000_0008, 8'hFF, '0); pr(4'h1, 64'h77, OKAY, 1);
        pg(1, 64'h7000_0010, 8'h0F, 64'h55); pb(4'h2, OKAY);
        run_txn(1, 1, 1, ac, rc, wc);
        chk("arb1_rd_first", rc < ac, 1);
        wait_idle();
        set_ar(4'h3, 64'h7000_0018, 8'd0);
        set_aw(4'h4, 64'h7000_0020, 8'd0); set_w(64'h99, 8'hF0, 1'b1);
        pg(1, 64'h7000_0020, 8'hF0, 64'h99); pb(4'h4, OKAY);
        pg(0, 64'h7000_0018, 8'hFF, '0); pr(4'h3, 64'h77, OKAY, 1);
        run_txn(1, 1, 1, ac, rc, wc);
        chk("arb2_wr_first", ac < rc, 1);
        wait_idle();

        // random single-beat traffic
        for (int i = 0; i < 8; i++) begin
            rdy_dly = $urandom_range(3);
            rsp_err = 1'($urandom_range(1));
            id = IW'($urandom);
            a = {32'h9000_0000, $urandom};
            d = {$urandom, $urandom};
            s = SW'($urandom);
            rsp_rdata = d;
            if ($urandom_range(1) == 1) begin
                set_aw(id, a, 8'd0); set_w(d, s, 1'b1);
                pg(1, a & ~64'h7, s, d); pb(id, rsp_err ? SLV : OKAY);
                run_txn(1, 0, 1, ac, rc, wc);
            end else begin
                set_ar(id, a, 8'd0);
                pg(0, a & ~64'h7, 8'hFF, '0); pr(id, d, rsp_err ? SLV : OKAY, 1);
                run_txn(0, 1, 0, ac, rc, wc);
            end
            wait_idle();
        end

        chk("queues_empty", exp_b.size() + exp_r.size() + exp_g.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
